// File: rtl/aes_pkg.sv
// Shared AES round-datapath types, matrix coefficients and GF(2^8) helpers.
// Used by mix_column_unit and mix_columns_engine.
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_col_t;

   localparam logic [7:0] AES_POLY = 8'h1b;

   // Top row of each matrix; row r is this row rotated right by r bytes.
   localparam logic [31:0] FWD_ROW = 32'h02030101;
   localparam logic [31:0] INV_ROW = 32'h0e0b0d09;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } mc_state_e;

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

   // All matrix coefficients fit in 4 bits, so four xtime steps suffice.
   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] acc;
      p   = a;
      acc = '0;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) acc = acc ^ p;
         p = gf_xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns transform.
// Byte r of the column sits at col[31-8r -: 8].
module mix_column_unit
   import aes_pkg::*;
(
   input  aes_col_t col_i,
   input  logic     inv_i,
   output aes_col_t col_o
);

   logic [31:0] row;
   logic [7:0]  acc;
   int          k;

   // Matrix-vector product over GF(2^8) with rotated coefficient rows.
   always_comb begin
      row   = inv_i ? INV_ROW : FWD_ROW;
      col_o = '0;
      acc   = '0;
      k     = 0;
      for (int r = 0; r < 4; r++) begin
         acc = '0;
         for (int j = 0; j < 4; j++) begin
            k   = (j - r + 4) % 4;
            acc = acc ^ gf_mul(col_i[31-8*j -: 8], row[27-8*k -: 4]);
         end
         col_o[31-8*r -: 8] = acc;
      end
   end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine, LANES columns per beat.
// Optional macro MIXCOL_PARITY_EN adds the out_parity byte-parity output.
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int LANES   = 1,
   parameter int OUT_REG = 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
`ifdef MIXCOL_PARITY_EN
   ,
   output logic [15:0]  out_parity
`endif
);

   localparam int        BEATS    = 4 / LANES;
   localparam logic [1:0] LAST    = 2'(BEATS - 1);
   localparam bit        COMB_ALL = (LANES == 4) && (OUT_REG == 0);

   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("mix_columns_engine: LANES must be 1, 2 or 4");
   end

   mc_state_e  state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   aes_state_t work_q, work_d;
   aes_state_t out_q, out_d;
   logic       inv_q, inv_d;

   aes_state_t src, xf;
   logic       src_inv;
   logic       last_beat, accept;
   logic [1:0] col_idx [LANES];
   aes_col_t   col_in  [LANES];
   aes_col_t   col_out [LANES];

   assign last_beat = (state_q == ST_BUSY) && (cnt_q == LAST);
   assign accept    = in_valid && in_ready;

   // Pick the source state and the columns handled in this beat.
   always_comb begin
      src     = COMB_ALL ? in_data : work_q;
      src_inv = COMB_ALL ? in_inv  : inv_q;
      for (int l = 0; l < LANES; l++) begin
         col_idx[l] = 2'(int'(cnt_q) * LANES + l);
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign col_in[l] = src[127-32*col_idx[l] -: 32];
      mix_column_unit u_col (
         .col_i (col_in[l]),
         .inv_i (src_inv),
         .col_o (col_out[l])
      );
   end

   // Source state with this beat's columns replaced in place.
   always_comb begin
      xf = src;
      for (int l = 0; l < LANES; l++) begin
         xf[127-32*col_idx[l] -: 32] = col_out[l];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept && !COMB_ALL) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (last_beat) begin
               if (OUT_REG != 0)   state_d = ST_DONE;
               else if (out_ready) state_d = accept ? ST_BUSY : ST_IDLE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = accept ? ST_BUSY : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: load on accept, transform per beat.
   always_comb begin
      cnt_d  = cnt_q;
      work_d = work_q;
      inv_d  = inv_q;
      out_d  = out_q;
      if (accept && !COMB_ALL) begin
         cnt_d  = '0;
         work_d = in_data;
         inv_d  = in_inv;
      end else if (state_q == ST_BUSY) begin
         if (!last_beat) begin
            work_d = xf;
            cnt_d  = cnt_q + 2'd1;
         end else if (OUT_REG != 0) begin
            work_d = xf;
            out_d  = xf;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         work_q <= '0;
         inv_q  <= 1'b0;
         out_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         work_q <= work_d;
         inv_q  <= inv_d;
         out_q  <= out_d;
      end
   end

   // Handshake and result outputs.
   always_comb begin
      busy = (state_q != ST_IDLE);
      if (OUT_REG != 0) begin
         out_valid = (state_q == ST_DONE);
         in_ready  = (state_q == ST_IDLE) ||
                     ((state_q == ST_DONE) && out_ready);
         out_data  = out_q;
      end else if (COMB_ALL) begin
         out_valid = in_valid;
         in_ready  = out_ready;
         out_data  = xf;
      end else begin
         out_valid = last_beat;
         in_ready  = (state_q == ST_IDLE) || (last_beat && out_ready);
         out_data  = xf;
      end
   end

`ifdef MIXCOL_PARITY_EN
   function automatic logic [15:0] byte_par(input aes_state_t s);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 16; i++) p[15-i] = ^s[127-8*i -: 8];
      return p;
   endfunction

   logic [15:0] par_q;

   // Parity captured alongside the registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par_q <= '0;
      else if (last_beat && (OUT_REG != 0))
         par_q <= byte_par(xf);
   end

   assign out_parity = (OUT_REG != 0) ? par_q : byte_par(out_data);
`endif

endmodule
